// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NREQ requesters.
// Optional FIFO_ARB_FIXED_PRIO_EN: requester 0 wins in IDLE and preempts other owners' bursts.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               fifo_full,
  output logic [NREQ-1:0]    gnt,
  output logic               fifo_wr,
  output logic [DW-1:0]      fifo_data,
  output logic [2:0]         owner,
  output logic               busy
);

  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_e          state_q, state_d;
  logic [2:0]      rr_q, rr_d, owner_q, owner_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_d;
  logic            found, own_req;
  logic [2:0]      win, sel;

  function automatic logic [2:0] nxt(input logic [2:0] i);
    return (int'(i) == NREQ-1) ? 3'd0 : i + 3'd1;
  endfunction

  // First requester at or after rr_q, wrapping modulo NREQ.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    win   = rr_q;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && |(req & (ONE << j))) begin
        found = 1'b1;
        win   = 3'(j);
      end
    end
`ifdef FIFO_ARB_FIXED_PRIO_EN
    if (req[0]) begin
      found = 1'b1;
      win   = 3'd0;
    end
`endif
  end

  assign own_req = |(req & (ONE << owner_q));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    // Full freezes everything; stall beats never count toward the burst.
    if (!fifo_full) begin
      if (state_q == IDLE) begin
        if (found) begin
          gnt_d   = ONE << win;
          owner_d = win;
          cnt_d   = 4'd1;
          if (MAX_BURST == 1) rr_d = nxt(win);
          else                state_d = BURST;
        end
      end else if (!own_req) begin
        rr_d    = nxt(owner_q);
        state_d = IDLE;
      end else begin
        gnt_d = ONE << owner_q;
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == 4'(MAX_BURST)) begin
          rr_d    = nxt(owner_q);
          state_d = IDLE;
        end
`ifdef FIFO_ARB_FIXED_PRIO_EN
        if (req[0] && owner_q != 3'd0) begin
          rr_d    = nxt(owner_q);
          state_d = IDLE;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 3'd0;
      owner_q <= 3'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grants are combinational; reset masks them so nothing is written while it is held.
  assign gnt     = reset ? '0 : gnt_d;
  assign fifo_wr = |gnt;
  assign sel     = (state_q == IDLE) ? win : owner_q;
  assign owner   = owner_q;
  assign busy    = (state_q == BURST);

  always_comb begin
    fifo_data = '0;
    if (fifo_wr) fifo_data = req_data[int'(sel)*DW +: DW];
  end

endmodule
